// File: rtl/display_refresh_mux.sv
// N-digit time-multiplexed seven-segment refresh controller with prescaler,
// per-digit blanking, decimal-point routing and frame-start strobe.
// Optional anode dead-time guard: define DISP_DEADTIME_EN.
module display_refresh_mux #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int DEAD_CYC = 2,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Cen,
    input  logic [4*DIGITS-1:0]   InD,
    input  logic [DIGITS-1:0]     DigEn,
    input  logic [DIGITS-1:0]     Dp,
    output logic [DIGITS-1:0]     An,
    output logic [3:0]            OutR,
    output logic                  DpOut,
    output logic [IW-1:0]         DigIdx,
    output logic                  FrameStart
);

    logic [PW-1:0]     pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [3:0]        outr_q, outr_d;
    logic              dp_q, dp_d;
    logic              fs_q, fs_d;

    logic              tick;
    logic [IW-1:0]     sel;
    logic [DIGITS-1:0] sel_hot;
    logic [3:0]        nib_arr [DIGITS];

    assign tick = Cen && (pre_q == PW'(PRESCALE - 1));
    assign sel  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    // Decoded slot and nibble lanes; sel never exceeds DIGITS-1.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_lane
            assign sel_hot[gi] = (sel == IW'(gi));
            assign nib_arr[gi] = InD[4*gi +: 4];
        end
    endgenerate

`ifdef DISP_DEADTIME_EN
    localparam int GW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    logic [GW-1:0]     guard_q, guard_d;
    logic [DIGITS-1:0] pend_q, pend_d;
`endif

    always_comb begin
        pre_d  = pre_q;
        idx_d  = idx_q;
        an_d   = an_q;
        outr_d = outr_q;
        dp_d   = dp_q;
        fs_d   = 1'b0;
`ifdef DISP_DEADTIME_EN
        guard_d = guard_q;
        pend_d  = pend_q;
`endif
        if (tick) begin
            pre_d  = '0;
            idx_d  = sel;
            outr_d = nib_arr[sel];
            dp_d   = Dp[sel] & DigEn[sel];
            an_d   = sel_hot & DigEn;
            fs_d   = (sel == '0);
`ifdef DISP_DEADTIME_EN
            // Hold anodes dark for DEAD_CYC enabled cycles before driving the new digit.
            if (DEAD_CYC > 0) begin
                pend_d  = sel_hot & DigEn;
                an_d    = '0;
                guard_d = DigEn[sel] ? GW'(DEAD_CYC) : '0;
            end
`endif
        end else if (Cen) begin
            pre_d = pre_q + 1'b1;
`ifdef DISP_DEADTIME_EN
            if (guard_q != '0) begin
                guard_d = guard_q - 1'b1;
                if (guard_q == GW'(1)) begin
                    an_d = pend_q;
                end
            end
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pre_q  <= '0;
            idx_q  <= IW'(DIGITS - 1);
            an_q   <= '0;
            outr_q <= '0;
            dp_q   <= 1'b0;
            fs_q   <= 1'b0;
`ifdef DISP_DEADTIME_EN
            guard_q <= '0;
            pend_q  <= '0;
`endif
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            outr_q <= outr_d;
            dp_q   <= dp_d;
            fs_q   <= fs_d;
`ifdef DISP_DEADTIME_EN
            guard_q <= guard_d;
            pend_q  <= pend_d;
`endif
        end
    end

    assign An         = an_q;
    assign OutR       = outr_q;
    assign DpOut      = dp_q;
    assign DigIdx     = idx_q;
    assign FrameStart = fs_q;

endmodule

// File: tb/tb_display_refresh_mux.sv
// Self-checking bench for display_refresh_mux: directed scenarios plus
// randomized traffic against a slot-counting reference model.
module tb_display_refresh_mux;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 3;
    localparam int DEAD_CYC = 1;
    localparam int IW       = 2;
    localparam int VW       = DIGITS + 4 + 1 + IW + 1;
`ifdef DISP_DEADTIME_EN
    localparam bit DT_ON = 1'b1;
`else
    localparam bit DT_ON = 1'b0;
`endif

    logic                Clk = 1'b0;
    logic                Rst = 1'b1;
    logic                Cen = 1'b0;
    logic [4*DIGITS-1:0] InD = '0;
    logic [DIGITS-1:0]   DigEn = '0;
    logic [DIGITS-1:0]   Dp = '0;
    logic [DIGITS-1:0]   An;
    logic [3:0]          OutR;
    logic                DpOut;
    logic [IW-1:0]       DigIdx;
    logic                FrameStart;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: counts Cen-high cycles since reset; every PRESCALE-th one is a new slot.
    int                m_cnt, m_ticks, m_since;
    logic [DIGITS-1:0] m_an;
    logic [3:0]        m_out;
    logic              m_dp, m_fs;
    logic [IW-1:0]     m_idx;

    display_refresh_mux #(
        .DIGITS  (DIGITS),
        .PRESCALE(PRESCALE),
        .DEAD_CYC(DEAD_CYC)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Cen       (Cen),
        .InD       (InD),
        .DigEn     (DigEn),
        .Dp        (Dp),
        .An        (An),
        .OutR      (OutR),
        .DpOut     (DpOut),
        .DigIdx    (DigIdx),
        .FrameStart(FrameStart)
    );

    always #5 Clk = ~Clk;

    function automatic logic [VW-1:0] exp_vec();
        logic [DIGITS-1:0] a;
        a = (DT_ON && m_since < DEAD_CYC) ? '0 : m_an;
        return {a, m_out, m_dp, m_idx, m_fs};
    endfunction

    task automatic step(input logic rst, input logic cen);
        int d;
        Rst = rst;
        Cen = cen;
        @(posedge Clk);
        if (rst) begin
            m_cnt = 0; m_ticks = 0; m_since = 1000;
            m_an = '0; m_out = '0; m_dp = 1'b0; m_fs = 1'b0;
            m_idx = IW'(DIGITS - 1);
        end else begin
            m_fs = 1'b0;
            if (cen) begin
                m_cnt++;
                m_since++;
                if (m_cnt % PRESCALE == 0) begin
                    m_ticks++;
                    d       = (m_ticks - 1) % DIGITS;
                    m_idx   = IW'(d);
                    m_out   = InD[4*d +: 4];
                    m_dp    = Dp[d] && DigEn[d];
                    m_an    = DigEn[d] ? DIGITS'(1 << d) : '0;
                    m_fs    = (d == 0);
                    m_since = 0;
                end
            end
        end
        #1;
        cycle++;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (An !== '0 || OutR !== 4'h0 || DpOut !== 1'b0 || FrameStart !== 1'b0 || DigIdx !== 2'd3) begin
            errors++;
            $display("FAIL reset_state cyc=%0d got An=%b OutR=%h Dp=%b Idx=%0d Fs=%b want 0000 0 0 3 0",
                     cycle, An, OutR, DpOut, DigIdx, FrameStart);
        end
        InD = 16'h4321; DigEn = 4'hF; Dp = 4'h0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (An !== '0 || FrameStart !== 1'b0) begin
                errors++;
                $display("FAIL first_slot_wait cyc=%0d got An=%b Fs=%b want 0000 0", cycle, An, FrameStart);
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if (An !== (DT_ON ? 4'b0000 : 4'b0001) || OutR !== 4'h1 || DigIdx !== 2'd0 || FrameStart !== 1'b1) begin
            errors++;
            $display("FAIL first_slot cyc=%0d got An=%b OutR=%h Idx=%0d Fs=%b want %b 1 0 1",
                     cycle, An, OutR, DigIdx, FrameStart, DT_ON ? 4'b0000 : 4'b0001);
        end
    endtask

    task automatic test_rotation();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if ({An, OutR, DpOut, DigIdx, FrameStart} !== exp_vec()) begin
                errors++;
                $display("FAIL rotation cyc=%0d got %b want %b", cycle,
                         {An, OutR, DpOut, DigIdx, FrameStart}, exp_vec());
            end
        end
    endtask

    task automatic test_blank_dp();
        DigEn = 4'b1011; Dp = 4'b0110;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if ({An, OutR, DpOut, DigIdx, FrameStart} !== exp_vec()) begin
                errors++;
                $display("FAIL blank_dp cyc=%0d got %b want %b", cycle,
                         {An, OutR, DpOut, DigIdx, FrameStart}, exp_vec());
            end
            if (DigIdx == 2'd2 && m_ticks > 0) begin
                checks++;
                if (An !== '0 || OutR !== 4'h3 || DpOut !== 1'b0) begin
                    errors++;
                    $display("FAIL blank_slot2 cyc=%0d got An=%b OutR=%h Dp=%b want 0000 3 0",
                             cycle, An, OutR, DpOut);
                end
            end
        end
        DigEn = 4'hF; Dp = 4'h0;
    endtask

    task automatic test_cen_gating();
        logic [VW-1:0] held;
        step(1'b0, 1'b1);
        held = {An, OutR, DpOut, DigIdx, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if ({An, OutR, DpOut, DigIdx, FrameStart} !== held || held !== exp_vec()) begin
                errors++;
                $display("FAIL cen_hold cyc=%0d got %b want %b", cycle,
                         {An, OutR, DpOut, DigIdx, FrameStart}, exp_vec());
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if ({An, OutR, DpOut, DigIdx, FrameStart} !== exp_vec()) begin
                errors++;
                $display("FAIL cen_resume cyc=%0d got %b want %b", cycle,
                         {An, OutR, DpOut, DigIdx, FrameStart}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (DigIdx !== 2'd2 && guard < 20) begin
            step(1'b0, 1'b1);
            guard++;
        end
        checks++;
        if (DigIdx !== 2'd2) begin
            errors++;
            $display("FAIL reach_slot2 got Idx=%0d want 2", DigIdx);
        end
        step(1'b1, 1'b1);
        checks++;
        if (An !== '0 || OutR !== 4'h0 || DigIdx !== 2'd3 || FrameStart !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid cyc=%0d got An=%b OutR=%h Idx=%0d Fs=%b want 0000 0 3 0",
                     cycle, An, OutR, DigIdx, FrameStart);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        checks++;
        if (DigIdx !== 2'd0 || FrameStart !== 1'b1 || OutR !== InD[3:0]) begin
            errors++;
            $display("FAIL restart cyc=%0d got Idx=%0d Fs=%b OutR=%h want 0 1 %h",
                     cycle, DigIdx, FrameStart, OutR, InD[3:0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) InD = 16'($urandom);
            if ($urandom_range(0, 7) == 0) DigEn = 4'($urandom);
            if ($urandom_range(0, 7) == 0) Dp = 4'($urandom);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) != 0));
            checks++;
            if ({An, OutR, DpOut, DigIdx, FrameStart} !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got %b want %b", cycle,
                         {An, OutR, DpOut, DigIdx, FrameStart}, exp_vec());
            end
            checks++;
            if (!$onehot0(An)) begin
                errors++;
                $display("FAIL onehot cyc=%0d got An=%b want one-hot or zero", cycle, An);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_blank_dp();
        test_cen_gating();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
